// File: rtl/jtdd_rom_arb_if.sv
// Requester and SDRAM-side signals of jtdd_rom_arb.
// The slave modport is the arbiter's view; master is the view of whoever drives the requesters and the SDRAM.
interface jtdd_rom_arb_if #(
  parameter int AW0 = 19,
  parameter int AW1 = 17,
  parameter int AW2 = 15
);
  logic           obj_cs;
  logic           scr_cs;
  logic           chr_cs;
  logic [AW0-1:0] obj_addr;
  logic [AW1-1:0] scr_addr;
  logic [AW2-1:0] chr_addr;
  logic [15:0]    obj_data;
  logic [15:0]    scr_data;
  logic [15:0]    chr_data;
  logic           obj_ok;
  logic           scr_ok;
  logic           chr_ok;
  logic [21:0]    sdram_addr;
  logic           sdram_req;
  logic           sdram_ack;
  logic           sdram_dst;
  logic [15:0]    sdram_dout;

  modport slave (
    input  obj_cs, scr_cs, chr_cs, obj_addr, scr_addr, chr_addr,
    output obj_data, scr_data, chr_data, obj_ok, scr_ok, chr_ok,
    output sdram_addr, sdram_req,
    input  sdram_ack, sdram_dst, sdram_dout
  );

  modport master (
    output obj_cs, scr_cs, chr_cs, obj_addr, scr_addr, chr_addr,
    input  obj_data, scr_data, chr_data, obj_ok, scr_ok, chr_ok,
    input  sdram_addr, sdram_req,
    output sdram_ack, sdram_dst, sdram_dout
  );
endinterface

// File: rtl/jtdd_rom_arb.sv
// Three single-word ROM caches (obj/scr/chr) sharing one SDRAM port; JTDD_ROMARB_RR_EN selects round-robin, else obj>scr>chr.
// Latency: pending -> sdram_req +1 cycle, sdram_dst -> ok +1 cycle; sdram_req held until sdram_ack, one access in flight.
module jtdd_rom_arb #(
  parameter int          AW0  = 19,
  parameter int          AW1  = 17,
  parameter int          AW2  = 15,
  parameter logic [21:0] OFS0 = 22'h0,
  parameter logic [21:0] OFS1 = 22'h80000,
  parameter logic [21:0] OFS2 = 22'hA0000
) (
  input  logic             clk,
  input  logic             rst_n,
  jtdd_rom_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;
  logic        sdram_req_q, sdram_req_d;
  logic [15:0] data_q [3];
  logic [15:0] data_d [3];
  logic [21:0] tag_q  [3];
  logic [21:0] tag_d  [3];
  logic [2:0]  valid_q, valid_d;

  logic [2:0]  cs;
  logic [2:0]  ok;
  logic [2:0]  pending;
  logic [21:0] addr_ext [3];
  logic [21:0] word_addr [3];
  logic [1:0]  sel;

  // Tags hold the requester address zero-extended, so one comparator width serves all three.
  assign cs          = {bus.chr_cs, bus.scr_cs, bus.obj_cs};
  assign addr_ext[0] = 22'(bus.obj_addr);
  assign addr_ext[1] = 22'(bus.scr_addr);
  assign addr_ext[2] = 22'(bus.chr_addr);
  assign word_addr[0] = OFS0 + addr_ext[0];
  assign word_addr[1] = OFS1 + addr_ext[1];
  assign word_addr[2] = OFS2 + addr_ext[2];

  always_comb begin
    ok      = 3'b000;
    pending = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ok[i]      = cs[i] & valid_q[i] & (addr_ext[i] == tag_q[i]);
      pending[i] = cs[i] & ~ok[i];
    end
  end

`ifdef JTDD_ROMARB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Walk the search order backwards so the earliest pending requester is the one left in sel.
  always_comb begin
    sel = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (pending[rr_idx(rr_ptr_q, 2'(k))]) begin
        sel = rr_idx(rr_ptr_q, 2'(k));
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && |pending) begin
      rr_ptr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    sel = 2'd0;
    if (pending[0]) begin
      sel = 2'd0;
    end else if (pending[1]) begin
      sel = 2'd1;
    end else if (pending[2]) begin
      sel = 2'd2;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    sdram_addr_d = sdram_addr_q;
    sdram_req_d  = sdram_req_q;
    valid_d      = valid_q;
    for (int i = 0; i < 3; i++) begin
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          gnt_d          = sel;
          tag_d[sel]     = addr_ext[sel];
          valid_d[sel]   = 1'b0;
          sdram_addr_d   = word_addr[sel];
          sdram_req_d    = 1'b1;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          // Controller may return data in the same cycle it accepts the request.
          if (bus.sdram_dst) begin
            data_d[gnt_q]  = bus.sdram_dout;
            valid_d[gnt_q] = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bus.sdram_dst) begin
          data_d[gnt_q]  = bus.sdram_dout;
          valid_d[gnt_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sdram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'd0;
      sdram_addr_q <= 22'd0;
      sdram_req_q  <= 1'b0;
      valid_q      <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= 16'd0;
        tag_q[i]  <= 22'd0;
      end
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_req_q  <= sdram_req_d;
      valid_q      <= valid_d;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign bus.obj_data   = data_q[0];
  assign bus.scr_data   = data_q[1];
  assign bus.chr_data   = data_q[2];
  assign bus.obj_ok     = ok[0];
  assign bus.scr_ok     = ok[1];
  assign bus.chr_ok     = ok[2];
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.sdram_req  = sdram_req_q;

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: directed scenarios plus random requester traffic, checked against a per-requester cache model.
module tb_jtdd_rom_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtdd_rom_arb_if #(.AW0(19), .AW1(17), .AW2(15)) bus ();

  jtdd_rom_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference: what each requester's single-word cache should hold, and whose turn is next.
  logic        m_valid [3];
  logic [21:0] m_tag   [3];
  logic [15:0] m_data  [3];
  int          m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 22'd0;
      m_data[i]  = 16'd0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [21:0] ofs(input int i);
    case (i)
      0:       return 22'h0;
      1:       return 22'h80000;
      default: return 22'hA0000;
    endcase
  endfunction

  function automatic logic [21:0] cur_addr(input int i);
    case (i)
      0:       return 22'(bus.obj_addr);
      1:       return 22'(bus.scr_addr);
      default: return 22'(bus.chr_addr);
    endcase
  endfunction

  function automatic logic cur_cs(input int i);
    case (i)
      0:       return bus.obj_cs;
      1:       return bus.scr_cs;
      default: return bus.chr_cs;
    endcase
  endfunction

  function automatic logic exp_ok(input int i);
    return cur_cs(i) && m_valid[i] && (m_tag[i] == cur_addr(i));
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < 3; k++) begin
`ifdef JTDD_ROMARB_RR_EN
      int i = (m_ptr + k) % 3;
`else
      int i = k;
`endif
      if (cur_cs(i) && !exp_ok(i)) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    check($sformatf("%s obj_ok", tag),   32'(bus.obj_ok),   32'(exp_ok(0)));
    check($sformatf("%s scr_ok", tag),   32'(bus.scr_ok),   32'(exp_ok(1)));
    check($sformatf("%s chr_ok", tag),   32'(bus.chr_ok),   32'(exp_ok(2)));
    check($sformatf("%s obj_data", tag), 32'(bus.obj_data), 32'(m_data[0]));
    check($sformatf("%s scr_data", tag), 32'(bus.scr_data), 32'(m_data[1]));
    check($sformatf("%s chr_data", tag), 32'(bus.chr_data), 32'(m_data[2]));
  endtask

  // Plays the SDRAM side for one access and updates the model with what should have been fetched.
  task automatic serve_one(input string tag, input int ack_dly, input int dst_dly, input bit same,
                           input logic [15:0] d, input bit chg, input logic [14:0] chr_new);
    int          g;
    int          w;
    logic [21:0] ea;
    logic [21:0] t;
    g = exp_grant();
    if (g < 0) begin
      check($sformatf("%s grant_expected", tag), 32'd0, 32'd1);
      return;
    end
    t  = cur_addr(g);
    ea = ofs(g) + t;
    w  = 0;
    while (!bus.sdram_req && w < 8) begin
      tick();
      w++;
    end
    check($sformatf("%s sdram_req", tag), 32'(bus.sdram_req), 32'd1);
    check($sformatf("%s sdram_addr", tag), 32'(bus.sdram_addr), 32'(ea));
    m_valid[g] = 1'b0;
    m_tag[g]   = t;
    m_ptr      = (g + 1) % 3;
    repeat (ack_dly) tick();
    if (same) begin
      bus.sdram_ack = 1'b1; bus.sdram_dst = 1'b1; bus.sdram_dout = d;
      tick();
      bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0;
    end else begin
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      check($sformatf("%s req_drop", tag), 32'(bus.sdram_req), 32'd0);
      if (chg) bus.chr_addr = chr_new;
      repeat (dst_dly) tick();
      bus.sdram_dst = 1'b1; bus.sdram_dout = d;
      tick();
      bus.sdram_dst = 1'b0;
    end
    m_valid[g] = 1'b1;
    m_data[g]  = d;
    check($sformatf("%s req_idle", tag), 32'(bus.sdram_req), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    bus.obj_cs = 1'b0; bus.scr_cs = 1'b0; bus.chr_cs = 1'b0;
    bus.obj_addr = '0; bus.scr_addr = '0; bus.chr_addr = '0;
    bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0; bus.sdram_dout = 16'd0;
    model_reset();

    // Reset state
    tick(); tick();
    check("rst sdram_req", 32'(bus.sdram_req), 32'd0);
    check("rst sdram_addr", 32'(bus.sdram_addr), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    tick();

    // All three requesters want new words at once
    bus.obj_cs = 1'b1; bus.obj_addr = 19'h40000;
    bus.scr_cs = 1'b1; bus.scr_addr = 17'h1FFFF;
    bus.chr_cs = 1'b1; bus.chr_addr = 15'h7FFF;
    serve_one("multi0", 1, 1, 1'b0, 16'h1111, 1'b0, 15'h0);
    serve_one("multi1", 0, 2, 1'b0, 16'h2222, 1'b0, 15'h0);
    serve_one("multi2", 2, 0, 1'b0, 16'h3333, 1'b0, 15'h0);
    tick(); tick(); tick();
    check("multi no_extra_req", 32'(bus.sdram_req), 32'd0);
    check_outputs("multi_end");

    // Single scr fetch with exact request latency
    bus.obj_cs = 1'b0; bus.chr_cs = 1'b0;
    bus.scr_addr = 17'h1234;
    tick();
    check("scr req_latency", 32'(bus.sdram_req), 32'd1);
    check("scr addr", 32'(bus.sdram_addr), 32'h81234);
    serve_one("scr", 1, 2, 1'b0, 16'hBEEF, 1'b0, 15'h0);
    check("scr data_beef", 32'(bus.scr_data), 32'hBEEF);
    check("scr ok", 32'(bus.scr_ok), 32'd1);

    // obj hit, then address change drops ok combinationally and re-fetches
    bus.scr_cs = 1'b0;
    bus.obj_cs = 1'b1; bus.obj_addr = 19'h10;
    serve_one("obj10", 0, 0, 1'b0, 16'h0A10, 1'b0, 15'h0);
    check("obj10 ok", 32'(bus.obj_ok), 32'd1);
    bus.obj_addr = 19'h11;
    #1;
    check("obj11 ok_drop", 32'(bus.obj_ok), 32'd0);
    serve_one("obj11", 1, 1, 1'b0, 16'h0A11, 1'b0, 15'h0);

    // chr address moves while data is outstanding
    bus.obj_cs = 1'b0;
    bus.chr_cs = 1'b1; bus.chr_addr = 15'h0100;
    serve_one("chr_old", 1, 2, 1'b0, 16'hC100, 1'b1, 15'h0101);
    check("chr_old ok_low", 32'(bus.chr_ok), 32'd0);
    serve_one("chr_new", 0, 1, 1'b0, 16'hC101, 1'b0, 15'h0);
    check("chr_new ok", 32'(bus.chr_ok), 32'd1);

    // ack and dst in the same cycle
    bus.chr_addr = 15'h0123;
    serve_one("same", 1, 0, 1'b1, 16'h5A5A, 1'b0, 15'h0);
    check("same ok", 32'(bus.chr_ok), 32'd1);

    // Reset while data is outstanding, then a stray dst
    bus.chr_addr = 15'h0200;
    guard = 0;
    while (!bus.sdram_req && guard < 8) begin
      tick();
      guard++;
    end
    check("rstmid req", 32'(bus.sdram_req), 32'd1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rstmid sdram_req", 32'(bus.sdram_req), 32'd0);
    check("rstmid chr_ok", 32'(bus.chr_ok), 32'd0);
    model_reset();
    check_outputs("rstmid");
    tick();
    rst_n = 1'b1;
    bus.sdram_dst = 1'b1; bus.sdram_dout = 16'hDEAD;
    tick();
    bus.sdram_dst = 1'b0;
    check("stray ok", 32'(bus.chr_ok), 32'd0);
    check_outputs("stray");
    serve_one("after_rst", 0, 1, 1'b0, 16'h0200, 1'b0, 15'h0);

    // Random traffic over a small address pool so hits and misses both occur
    for (int it = 0; it < 30; it++) begin
      bus.obj_cs   = 1'($urandom);
      bus.scr_cs   = 1'($urandom);
      bus.chr_cs   = 1'($urandom);
      bus.obj_addr = 19'($urandom_range(0, 3));
      bus.scr_addr = 17'($urandom_range(0, 3));
      bus.chr_addr = 15'($urandom_range(0, 3));
      guard = 0;
      while (exp_grant() >= 0 && guard < 4) begin
        serve_one($sformatf("rnd%0d", it), $urandom_range(0, 2), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0, 15'h0);
        guard++;
      end
      tick();
      check($sformatf("rnd%0d quiet", it), 32'(bus.sdram_req), 32'd0);
      check_outputs($sformatf("rnd%0d end", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
